// File: rtl/game_ctrl_pkg.sv
// Shared state and message encodings for the game round controller.
package game_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_LIFE_LOST,
      S_LEVEL_CLEAR,
      S_GAME_OVER,
      S_VICTORY
   } state_t;

   typedef enum logic [2:0] {
      MSG_NONE  = 3'd0,
      MSG_LIFE  = 3'd1,
      MSG_CLEAR = 3'd2,
      MSG_OVER  = 3'd3,
      MSG_WIN   = 3'd4
   } msg_t;

   function automatic msg_t msg_of(input state_t st);
      case (st)
         S_LIFE_LOST:   return MSG_LIFE;
         S_LEVEL_CLEAR: return MSG_CLEAR;
         S_GAME_OVER:   return MSG_OVER;
         S_VICTORY:     return MSG_WIN;
         default:       return MSG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/game_round_ctrl_timer.sv
// Frame-pulse counter for on-screen message hold time; done fires on the
// tick that brings the count to MSG_FRAMES.
module round_msg_timer #(
   parameter int MSG_FRAMES = 120
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic done
);
   localparam int TW = $clog2(MSG_FRAMES + 1);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (tick && (count_reg != TW'(MSG_FRAMES)))
         count_reg <= count_reg + 1'b1;
   end

   assign done = tick && !clear && (count_reg == TW'(MSG_FRAMES - 1));

endmodule

// File: rtl/game_round_ctrl.sv
// Game-flow FSM: countdown reload, level/lives tracking, message selection.
// Optional turbo countdown for late levels is enabled by defining GAME_CTRL_TURBO_EN.
module game_round_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int NUM_LIVES   = 3,
   parameter int NUM_LEVELS  = 4,
   parameter int MSG_FRAMES  = 120,
   parameter int TURBO_LEVEL = 2,
   localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_key,
   input  logic          startOfFrame,
   input  logic          finishCount,
   input  logic          level_done,
   input  logic          player_hit,
   output logic          load,
   output logic          turbo,
   output logic [LW-1:0] level,
   output logic [2:0]    lives,
   output logic          game_active,
   output logic [2:0]    show_msg,
   output logic          game_over
);
`ifdef GAME_CTRL_TURBO_EN
   localparam bit TURBO_ON = 1'b1;
`else
   localparam bit TURBO_ON = 1'b0;
`endif

   state_t        state_reg;
   logic          start_d;
   logic          fc_d;
   logic [LW-1:0] level_reg;
   logic [2:0]    lives_reg;
   logic          start_rise;
   logic          fc_rise;
   logic          in_msg;
   logic          timer_done;

   assign start_rise = start_key & ~start_d;
   assign fc_rise    = finishCount & ~fc_d;
   assign in_msg     = (state_reg == S_LIFE_LOST) || (state_reg == S_LEVEL_CLEAR);

   // Timer is held cleared outside the message states, so it always starts from zero.
   round_msg_timer #(
      .MSG_FRAMES(MSG_FRAMES)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (!in_msg),
      .tick  (startOfFrame),
      .done  (timer_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         start_d   <= 1'b0;
         fc_d      <= 1'b0;
         level_reg <= '0;
         lives_reg <= 3'(NUM_LIVES);
      end else begin
         start_d <= start_key;
         fc_d    <= finishCount;
         case (state_reg)
            S_IDLE: if (start_rise) begin
               lives_reg <= 3'(NUM_LIVES);
               level_reg <= '0;
               state_reg <= S_LOAD;
            end
            S_LOAD: state_reg <= S_PLAY;
            S_PLAY: begin
               if (player_hit || fc_rise) begin
                  if (lives_reg != 3'd0)
                     lives_reg <= lives_reg - 3'd1;
                  state_reg <= S_LIFE_LOST;
               end else if (level_done) begin
                  state_reg <= S_LEVEL_CLEAR;
               end
            end
            S_LIFE_LOST: if (timer_done)
               state_reg <= (lives_reg == 3'd0) ? S_GAME_OVER : S_LOAD;
            S_LEVEL_CLEAR: if (timer_done) begin
               if (level_reg == LW'(NUM_LEVELS - 1)) begin
                  state_reg <= S_VICTORY;
               end else begin
                  level_reg <= level_reg + 1'b1;
                  state_reg <= S_LOAD;
               end
            end
            S_GAME_OVER, S_VICTORY: if (start_rise) state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign load        = (state_reg == S_LOAD);
   assign game_active = (state_reg == S_PLAY);
   assign game_over   = (state_reg == S_GAME_OVER);
   assign show_msg    = msg_of(state_reg);
   assign level       = level_reg;
   assign lives       = lives_reg;
   assign turbo       = TURBO_ON && (state_reg == S_PLAY) && (int'(level_reg) >= TURBO_LEVEL);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed self-checking bench for game_round_ctrl (default parameters).
module tb_game_round_ctrl;

   localparam int MSG_FRAMES = 120;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_key;
   logic       startOfFrame;
   logic       finishCount;
   logic       level_done;
   logic       player_hit;
   logic       load;
   logic       turbo;
   logic [1:0] level;
   logic [2:0] lives;
   logic       game_active;
   logic [2:0] show_msg;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_round_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .start_key    (start_key),
      .startOfFrame (startOfFrame),
      .finishCount  (finishCount),
      .level_done   (level_done),
      .player_hit   (player_hit),
      .load         (load),
      .turbo        (turbo),
      .level        (level),
      .lives        (lives),
      .game_active  (game_active),
      .show_msg     (show_msg),
      .game_over    (game_over)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Hold a message for MSG_FRAMES frame pulses; checks it is still shown before the last one.
   task automatic wait_msg(input logic [2:0] code);
      for (int i = 0; i < MSG_FRAMES; i++) begin
         if (i == MSG_FRAMES - 1) chk("msg_held", show_msg, code);
         startOfFrame = 1'b1;
         cyc();
         startOfFrame = 1'b0;
         if (i < MSG_FRAMES - 1) cyc();
      end
   endtask

   task automatic start_game();
      start_key = 1'b1;
      cyc();
      chk("start_load", load, 1);
      start_key = 1'b0;
      cyc();
      chk("start_play", game_active, 1);
   endtask

   initial begin
      int loads;
      logic exp_turbo;
      reset = 1'b1; start_key = 0; startOfFrame = 0; finishCount = 0;
      level_done = 0; player_hit = 0;
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("rst_load", load, 0);
      chk("rst_turbo", turbo, 0);
      chk("rst_level", level, 0);
      chk("rst_lives", lives, 3);
      chk("rst_active", game_active, 0);
      chk("rst_msg", show_msg, 0);
      chk("rst_over", game_over, 0);

      // start held high: single load the cycle after the rise
      start_key = 1'b1;
      cyc();
      chk("hold_load1", load, 1);
      chk("hold_active0", game_active, 0);
      cyc();
      chk("hold_load0", load, 0);
      chk("hold_active1", game_active, 1);
      loads = 0;
      for (int i = 0; i < 48; i++) begin
         cyc();
         if (load) loads++;
      end
      chk("hold_extra_loads", loads, 0);
      start_key = 1'b0;
      cyc();

      // reset in the middle of play
      reset = 1'b1;
      cyc();
      chk("midrst_active", game_active, 0);
      chk("midrst_lives", lives, 3);
      chk("midrst_level", level, 0);
      chk("midrst_msg", show_msg, 0);
      chk("midrst_load", load, 0);
      reset = 1'b0;
      cyc();
      start_game();

      // hit and goal together: loss wins
      player_hit = 1'b1; level_done = 1'b1;
      cyc();
      player_hit = 1'b0; level_done = 1'b0;
      chk("both_msg", show_msg, 1);
      chk("both_lives", lives, 2);
      chk("both_level", level, 0);
      chk("both_active", game_active, 0);
      wait_msg(3'd1);
      chk("life_exit_load", load, 1);
      chk("life_exit_msg", show_msg, 0);
      cyc();
      chk("life_replay", game_active, 1);

      // timeout via finishCount, held high across the reload
      finishCount = 1'b1;
      cyc();
      chk("fc_msg", show_msg, 1);
      chk("fc_lives", lives, 1);
      wait_msg(3'd1);
      chk("fc_exit_load", load, 1);
      cyc(); cyc(); cyc();
      chk("fc_held_active", game_active, 1);
      chk("fc_held_lives", lives, 1);
      finishCount = 1'b0;
      cyc();

      // third loss -> game over
      player_hit = 1'b1;
      cyc();
      player_hit = 1'b0;
      chk("loss3_lives", lives, 0);
      wait_msg(3'd1);
      chk("over_flag", game_over, 1);
      chk("over_msg", show_msg, 3);
      chk("over_load", load, 0);
      player_hit = 1'b1; finishCount = 1'b1;
      cyc();
      player_hit = 1'b0;
      chk("over_drop_lives", lives, 0);
      chk("over_stay", game_over, 1);
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
      chk("over_idle_flag", game_over, 0);
      chk("over_idle_msg", show_msg, 0);
      finishCount = 1'b0;
      cyc();

      // clear all four levels
      start_game();
      chk("new_lives", lives, 3);
      for (int lv = 0; lv < 4; lv++) begin
`ifdef GAME_CTRL_TURBO_EN
         exp_turbo = (lv >= 2);
`else
         exp_turbo = 1'b0;
`endif
         chk("play_level", level, lv);
         chk("play_turbo", turbo, exp_turbo);
         level_done = 1'b1;
         cyc();
         level_done = 1'b0;
         chk("clear_msg", show_msg, 2);
         chk("clear_turbo", turbo, 0);
         wait_msg(3'd2);
         if (lv < 3) begin
            chk("clear_load", load, 1);
            cyc();
         end
      end
      chk("win_msg", show_msg, 4);
      chk("win_level", level, 3);
      chk("win_active", game_active, 0);
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
      chk("win_idle_msg", show_msg, 0);
      cyc();
      start_game();
      chk("restart_level", level, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
